pulse_decoder: RTL and testbench
================================

PULSE_DECODER -- requirements
Module: pulse_decoder

Interface
REQ-001 SHALL have parameter PULSE_NUM_BITS, default 8, which sets the width of the pulse count field.
REQ-002 SHALL have parameter PULSE_WIDTH_BITS, default 8, which sets the width of the pulse width and idle timeout fields.
REQ-003 SHALL have port clk, input, 1 bit: system clock, the only clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_en, input, 1 bit: logic clock enable (decode tick).
REQ-006 SHALL have port in, input, 1 bit: the pulse train to decode; it is asynchronous to clk.
REQ-007 SHALL have port timeout, input, PULSE_WIDTH_BITS: idle end-of-train threshold, in ticks.
REQ-008 SHALL have port trigger, input, 1 bit: arm request.
REQ-009 SHALL have port pulse_count, output, PULSE_NUM_BITS: number of complete pulses.
REQ-010 SHALL have port pulse_width, output, PULSE_WIDTH_BITS: high width of the first pulse, in ticks.
REQ-011 SHALL have port err, output, 1 bit: width mismatch or counter saturation.
REQ-012 SHALL have port busy, output, 1 bit: a train is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-clk pulse at end of train.
REQ-014 SHALL have port rdy, output, 1 bit: trigger will be accepted.

Function
REQ-015 SHALL pass in through a 2-flop synchronizer clocked every clk, not gated by clk_en; the synchronized signal is in_s.
REQ-016 SHALL change state, counters and results only on cycles with clk_en=1; trigger SHALL be sampled only when clk_en=1.
REQ-017 SHALL implement states IDLE, ARMED, HIGH, LOW and DONE; rdy=1 in IDLE, ARMED and DONE; busy=1 in HIGH and LOW.
REQ-018 SHALL, on rdy & trigger with clk_en, latch timeout, clear pulse_count, pulse_width, err and the internal counters, and enter ARMED; re-triggering while in ARMED re-arms.
REQ-019 SHALL, in ARMED with in_s=1, enter HIGH with high counter = 1; an input already high at arm time counts as a pulse start. ARMED never times out.
REQ-020 SHALL, in HIGH with in_s=1, increment the high counter, saturating at all-ones and setting err on saturation.
REQ-021 SHALL, in HIGH with in_s=0 (falling edge):
- increment pulse_count, saturating at all-ones and setting err on saturation;
- if this is the first pulse, set pulse_width = high counter;
- otherwise set err if high counter != pulse_width;
- set idle counter = 1 and enter LOW, or enter DONE directly if latched timeout <= 1.
REQ-022 SHALL, in LOW with in_s=1, enter HIGH with high counter = 1 and idle counter unchanged.
REQ-023 SHALL, in LOW with in_s=0, increment the idle counter and enter DONE when the incremented value equals the latched timeout.
REQ-024 SHALL assert done for exactly one clk cycle, in the cycle after the transition into DONE.
REQ-025 SHALL hold pulse_count, pulse_width and err stable in DONE and IDLE until the next accepted trigger.
REQ-026 SHALL treat err as sticky until the next arm.
REQ-027 SHALL let arm take priority over all other transitions when trigger and an edge occur in the same tick from DONE.
REQ-028 SHALL freeze state and counters when clk_en=0, while the synchronizer keeps running.

Reset
REQ-029 SHALL, on reset low, asynchronously clear state to IDLE, clear both synchronizer flops, and drive pulse_count=0, pulse_width=0, err=0, busy=0, done=0, rdy=1.
REQ-030 SHALL, on reset asserted mid-train, abort immediately with no done pulse; after release the block is in IDLE.
REQ-031 SHALL release reset synchronously via clk, with no change to outputs until the first clk_en.

Verification
REQ-032 SHALL cover: clk_en=1, arm with timeout=4, drive 3 pulses of 2 high and 2 low ticks -> pulse_count=3, pulse_width=2, err=0, one done pulse 4 ticks after the last falling edge.
REQ-033 SHALL cover: pulses of high width 3, 3, 5 -> pulse_count=3, pulse_width=3, err=1.
REQ-034 SHALL cover: clk_en every 4th clk, pulses of 1 high tick and 1 low tick, times 5 -> pulse_count=5, pulse_width=1, and counters frozen between ticks.
REQ-035 SHALL cover: PULSE_NUM_BITS=2, 5 pulses -> pulse_count=3, err=1.
REQ-036 SHALL cover: reset low during HIGH of the 2nd pulse -> all outputs at reset values, rdy=1, done never asserted.
REQ-037 SHALL cover: timeout=1 with a single 2-tick pulse -> DONE on the falling-edge tick, pulse_count=1, and re-trigger in DONE clears results.

Source files
------------

// File: rtl/pulse_decoder.sv
// Pulse-train decoder: counts pulses, measures the first pulse width and flags
// width mismatches or saturation; a train ends after a programmable idle time.
module pulse_decoder #(
  parameter int unsigned PULSE_NUM_BITS   = 8,
  parameter int unsigned PULSE_WIDTH_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        in,
  input  logic [PULSE_WIDTH_BITS-1:0] timeout,
  input  logic                        trigger,
  output logic [PULSE_NUM_BITS-1:0]   pulse_count,
  output logic [PULSE_WIDTH_BITS-1:0] pulse_width,
  output logic                        err,
  output logic                        busy,
  output logic                        done,
  output logic                        rdy
);

  localparam int unsigned NW = PULSE_NUM_BITS;
  localparam int unsigned WW = PULSE_WIDTH_BITS;
  localparam logic [NW-1:0] CNT_MAX = '1;
  localparam logic [NW-1:0] CNT_ONE = NW'(1);
  localparam logic [WW-1:0] W_MAX   = '1;
  localparam logic [WW-1:0] W_ONE   = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_e;

  // Reset asserts asynchronously, releases two clocks after the pin goes high
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Input synchronizer runs every clock, independent of clk_en
  logic sync1_q;
  logic in_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      in_s_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      in_s_q  <= sync1_q;
    end
  end

  state_e          state_q, state_d;
  logic [WW-1:0]   timeout_q, timeout_d;
  logic [WW-1:0]   hi_q, hi_d;
  logic [WW-1:0]   idle_q, idle_d;
  logic [WW-1:0]   width_q, width_d;
  logic [NW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;
  logic            arm_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timeout_q <= '0;
      hi_q      <= '0;
      idle_q    <= '0;
      width_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      hi_q      <= hi_d;
      idle_q    <= idle_d;
      width_q   <= width_d;
      count_q   <= count_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
    end
  end

  assign arm_c = clk_en && trigger &&
                 ((state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    hi_d      = hi_q;
    idle_d    = idle_q;
    width_d   = width_q;
    count_d   = count_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (arm_c) begin
      // Arm wins over any edge seen in the same tick
      timeout_d = timeout;
      hi_d      = '0;
      idle_d    = '0;
      width_d   = '0;
      count_d   = '0;
      err_d     = 1'b0;
      state_d   = S_ARMED;
    end else if (clk_en) begin
      case (state_q)
        S_ARMED: begin
          if (in_s_q) begin
            hi_d    = W_ONE;
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (in_s_q) begin
            if (hi_q == W_MAX) begin
              err_d = 1'b1;
            end else begin
              hi_d = hi_q + W_ONE;
            end
          end else begin
            if (count_q == CNT_MAX) begin
              err_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
            // First pulse sets the reference width, later ones are compared to it
            if (count_q == '0) begin
              width_d = hi_q;
            end else if (hi_q != width_q) begin
              err_d = 1'b1;
            end
            idle_d  = W_ONE;
            state_d = (timeout_q <= W_ONE) ? S_DONE : S_LOW;
          end
        end
        S_LOW: begin
          if (in_s_q) begin
            hi_d    = W_ONE;
            state_d = S_HIGH;
          end else begin
            idle_d = idle_q + W_ONE;
            if (idle_d == timeout_q) begin
              state_d = S_DONE;
            end
          end
        end
        default: begin
        end
      endcase
      done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
    rdy_d  = !busy_d;
  end

  assign pulse_count = count_q;
  assign pulse_width = width_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdy         = rdy_q;

endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder: a directed vector table, hand sequences for the
// multi-cycle corners, and random traffic checked against a pulse-list model.
module tb_pulse_decoder;

  localparam int unsigned WB   = 8;
  localparam int          WMAX = 255;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          clk_en  = 1'b0;
  logic          din     = 1'b0;
  logic          trigger = 1'b0;
  logic [WB-1:0] timeout = 8'd4;

  logic [7:0]    cnt8;
  logic [WB-1:0] w8;
  logic          err8, busy8, done8, rdy8;
  logic [1:0]    cnt2;
  logic [WB-1:0] w2;
  logic          err2, busy2, done2, rdy2;

  int n_vec = 0;
  int n_err = 0;

  pulse_decoder #(.PULSE_NUM_BITS(8), .PULSE_WIDTH_BITS(WB)) u_dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in(din), .timeout(timeout),
    .trigger(trigger), .pulse_count(cnt8), .pulse_width(w8), .err(err8),
    .busy(busy8), .done(done8), .rdy(rdy8)
  );

  pulse_decoder #(.PULSE_NUM_BITS(2), .PULSE_WIDTH_BITS(WB)) u_dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in(din), .timeout(timeout),
    .trigger(trigger), .pulse_count(cnt2), .pulse_width(w2), .err(err2),
    .busy(busy2), .done(done2), .rdy(rdy2)
  );

  always #5 clk = ~clk;

  // Reference model: a train is the list of completed high-run lengths
  int unsigned m_w[$];
  bit m_open, m_run, m_sat, m_done;
  int m_hi, m_lo, m_to;
  bit h1, h2;

  function automatic void model_reset();
    m_w.delete();
    m_open = 0; m_run = 0; m_sat = 0; m_done = 0;
    m_hi = 0; m_lo = 0; m_to = 0; h1 = 0; h2 = 0;
  endfunction

  function automatic void end_train();
    m_open = 0; m_run = 0; m_done = 1;
  endfunction

  function automatic void model_tick(input bit en, input bit trig, input bit inv, input int to);
    bit ins;
    ins = h2; h2 = h1; h1 = inv;
    m_done = 0;
    if (!en) return;
    if (!(m_open && m_run) && trig) begin
      m_w.delete(); m_sat = 0; m_to = to; m_open = 1; m_run = 0; m_hi = 0; m_lo = 0;
    end else if (m_open) begin
      if (ins) begin
        m_hi++; m_run = 1;
        if (m_hi > WMAX) m_sat = 1;
      end else if (m_hi > 0) begin
        m_w.push_back((m_hi > WMAX) ? WMAX : m_hi);
        m_hi = 0; m_lo = 1;
        if (m_to <= 1) end_train();
      end else if (m_run) begin
        m_lo++;
        if (m_lo == m_to) end_train();
      end
    end
  endfunction

  task automatic check_model(input string name);
    int n, ec8, ec2, ew;
    bit mis, ee8, ee2, eb, ed, er;
    n = m_w.size();
    mis = 0;
    foreach (m_w[i]) if (m_w[i] != m_w[0]) mis = 1;
    ec8 = (n > 255) ? 255 : n;
    ec2 = (n > 3) ? 3 : n;
    ew  = (n > 0) ? int'(m_w[0]) : 0;
    ee8 = m_sat || mis || (n > 255);
    ee2 = m_sat || mis || (n > 3);
    eb  = m_open && m_run;
    ed  = m_done;
    er  = !eb;
    n_vec++;
    if (cnt8 !== 8'(ec8) || w8 !== 8'(ew) || err8 !== ee8 || busy8 !== eb || done8 !== ed ||
        rdy8 !== er || cnt2 !== 2'(ec2) || w2 !== 8'(ew) || err2 !== ee2 || busy2 !== eb ||
        done2 !== ed || rdy2 !== er) begin
      n_err++;
      $display("FAIL %s t=%0t: got c8=%0d c2=%0d w=%0d/%0d e=%0b/%0b b=%0b/%0b d=%0b/%0b r=%0b/%0b want c8=%0d c2=%0d w=%0d e=%0b/%0b b=%0b d=%0b r=%0b",
               name, $time, cnt8, cnt2, w8, w2, err8, err2, busy8, busy2, done8, done2,
               rdy8, rdy2, ec8, ec2, ew, ee8, ee2, eb, ed, er);
    end
  endtask

  task automatic check_const(input string name, input int c, input int w, input bit e,
                             input bit b, input bit d, input bit r);
    n_vec++;
    if (cnt8 !== 8'(c) || w8 !== 8'(w) || err8 !== e || busy8 !== b || done8 !== d || rdy8 !== r) begin
      n_err++;
      $display("FAIL %s t=%0t: got cnt=%0d w=%0d err=%0b busy=%0b done=%0b rdy=%0b want cnt=%0d w=%0d err=%0b busy=%0b done=%0b rdy=%0b",
               name, $time, cnt8, w8, err8, busy8, done8, rdy8, c, w, e, b, d, r);
    end
  endtask

  task automatic step(input bit en, input bit trig, input bit inv);
    clk_en = en; trigger = trig; din = inv;
    @(posedge clk);
    if (!reset) model_reset();
    else model_tick(en, trig, inv, int'(timeout));
    #1;
  endtask

  task automatic step_chk(input bit en, input bit trig, input bit inv, input string name);
    step(en, trig, inv);
    check_model(name);
  endtask

  // One decode tick spread over 'period' clocks with clk_en on the last
  task automatic tick(input int period, input bit inv, input string name);
    for (int k = 0; k < period - 1; k++) step_chk(0, 0, inv, name);
    step_chk(1, 0, inv, name);
  endtask

  task automatic pulse(input int hi, input int lo, input int period, input string name);
    for (int k = 0; k < hi; k++) tick(period, 1'b1, name);
    for (int k = 0; k < lo; k++) tick(period, 1'b0, name);
  endtask

  task automatic arm(input int to, input string name);
    timeout = 8'(to);
    step_chk(1, 1, 0, name);
  endtask

  typedef struct {
    bit en; bit trig; bit inv;
    int cnt; int w; bit err; bit busy; bit done; bit rdy;
  } vec_t;

  function automatic vec_t mk(input bit trig, input bit inv, input int c, input int w,
                              input bit b, input bit d, input bit r);
    vec_t v;
    v.en = 1; v.trig = trig; v.inv = inv;
    v.cnt = c; v.w = w; v.err = 0; v.busy = b; v.done = d; v.rdy = r;
    return v;
  endfunction

  initial begin
    vec_t tbl[18];
    int   run;
    bit   rin;

    // Three pulses of 2 high / 2 low, timeout 4
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 1, 2, 1, 0, 0);
    tbl[6]  = mk(0, 1, 1, 2, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 2, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 2, 1, 0, 0);
    tbl[9]  = mk(0, 1, 2, 2, 1, 0, 0);
    tbl[10] = mk(0, 1, 2, 2, 1, 0, 0);
    tbl[11] = mk(0, 0, 2, 2, 1, 0, 0);
    tbl[12] = mk(0, 0, 2, 2, 1, 0, 0);
    tbl[13] = mk(0, 0, 3, 2, 1, 0, 0);
    tbl[14] = mk(0, 0, 3, 2, 1, 0, 0);
    tbl[15] = mk(0, 0, 3, 2, 1, 0, 0);
    tbl[16] = mk(0, 0, 3, 2, 0, 1, 1);
    tbl[17] = mk(0, 0, 3, 2, 0, 0, 1);

    model_reset();
    #2 reset = 1'b0;
    repeat (3) step_chk(1, 1, 0, "in_reset");
    check_const("reset_state", 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    repeat (3) step_chk(1, 0, 0, "reset_release");
    check_const("post_release_idle", 0, 0, 0, 0, 0, 1);

    timeout = 8'd4;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].trig, tbl[i].inv);
      check_model("table_model");
      check_const("table", tbl[i].cnt, tbl[i].w, tbl[i].err, tbl[i].busy, tbl[i].done, tbl[i].rdy);
    end

    // Widths 3, 3, 5
    arm(4, "mismatch_arm");
    pulse(3, 2, 1, "mismatch");
    pulse(3, 2, 1, "mismatch");
    pulse(5, 8, 1, "mismatch");
    check_const("width_mismatch", 3, 3, 1, 0, 0, 1);

    // clk_en every 4th clock, five 1/1 pulses
    arm(4, "slow_arm");
    for (int k = 0; k < 5; k++) pulse(1, 1, 4, "slow_en");
    pulse(0, 6, 4, "slow_en_tail");
    check_const("slow_en_result", 5, 1, 0, 0, 0, 1);

    // Five pulses into a 2-bit counter
    arm(4, "sat_arm");
    for (int k = 0; k < 5; k++) pulse(2, 2, 1, "cnt_sat");
    pulse(0, 8, 1, "cnt_sat_tail");
    n_vec++;
    if (cnt2 !== 2'd3 || err2 !== 1'b1) begin
      n_err++;
      $display("FAIL cnt2_saturation: got cnt=%0d err=%0b want cnt=3 err=1", cnt2, err2);
    end
    check_const("cnt8_no_sat", 5, 2, 0, 0, 0, 1);

    // High-width counter saturation
    arm(3, "wsat_arm");
    pulse(260, 6, 1, "width_sat");
    check_const("width_sat_result", 1, 255, 1, 0, 0, 1);

    // Reset during the high phase of the second pulse
    arm(4, "abort_arm");
    pulse(2, 2, 1, "abort");
    repeat (3) step_chk(1, 0, 1, "abort_high");
    check_const("abort_busy", 1, 2, 0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_const("abort_async", 0, 0, 0, 0, 0, 1);
    repeat (3) step_chk(1, 0, 1, "abort_held");
    reset = 1'b1;
    repeat (4) step_chk(1, 0, 0, "abort_release");
    check_const("abort_idle", 0, 0, 0, 0, 0, 1);

    // Timeout 1: done on the falling-edge tick, then re-arm from DONE with an edge
    arm(1, "to1_arm");
    pulse(2, 2, 1, "to1");
    check_const("to1_last_low", 0, 0, 0, 1, 0, 0);
    step_chk(1, 0, 0, "to1_fall");
    check_const("to1_done", 1, 2, 0, 0, 1, 1);
    step_chk(1, 0, 1, "to1_hold");
    step_chk(1, 0, 1, "to1_hold");
    check_const("to1_held", 1, 2, 0, 0, 0, 1);
    step_chk(1, 1, 1, "rearm_priority");
    check_const("rearm_clears", 0, 0, 0, 0, 0, 1);
    step_chk(1, 0, 0, "rearm_high");
    check_const("rearm_starts", 0, 0, 0, 1, 0, 0);
    pulse(0, 4, 1, "rearm_tail");

    // Random traffic against the model
    run = 0;
    rin = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        rin = ($urandom % 2) == 1;
        run = $urandom_range(1, 6);
      end
      run--;
      if (($urandom % 60) == 0) timeout = 8'($urandom_range(0, 7));
      step_chk(($urandom % 4) != 0, ($urandom % 20) == 0, rin, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
